// File: rtl/sc_downcounter_pkg.sv
// sc_downcounter_pkg: state encodings and sizing helper for the down-counter timer
package sc_downcounter_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUN     = 2'b01;
    localparam logic [1:0] EXPIRED = 2'b10;

    function automatic int clog2Min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sc_prescaler.sv
// sc_prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one as a tick
module sc_prescaler import sc_downcounter_pkg::*; #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic rstN,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = clog2Min1(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Clear wins; otherwise advance while enabled and wrap on the tick
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/sc_downcounter_timer.sv
// sc_downcounter_timer: loadable prescaled down-counter with run/pause/expire control
module sc_downcounter_timer import sc_downcounter_pkg::*; #(
    parameter int DATAWIDTH   = 8,
    parameter int PRESCALE    = 50,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                 SC_downCOUNTER_CLOCK_50,
    input  logic                 SC_downCOUNTER_RESET_InLow,
    input  logic                 SC_downCOUNTER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_downCOUNTER_preset_InBUS,
    input  logic                 SC_downCOUNTER_start_InLow,
    input  logic                 SC_downCOUNTER_pause_InLow,
    output logic [DATAWIDTH-1:0] SC_downCOUNTER_data_OutBUS,
    output logic                 SC_downCOUNTER_zero_Out,
    output logic                 SC_downCOUNTER_tc_Out,
    output logic                 SC_downCOUNTER_busy_Out
);

    logic [1:0]           state;
    logic [DATAWIDTH-1:0] count;
    logic [DATAWIDTH-1:0] reloadValue;
    logic                 tcReg;
    logic                 tick;
    logic                 startOk;

    assign startOk = (state == IDLE) && !SC_downCOUNTER_start_InLow && (count != '0);

    sc_prescaler #(.PRESCALE(PRESCALE)) prescaler (
        .clk    (SC_downCOUNTER_CLOCK_50),
        .rstN   (SC_downCOUNTER_RESET_InLow),
        .enable ((state == RUN) && SC_downCOUNTER_pause_InLow),
        .clear  (!SC_downCOUNTER_load_InLow || startOk),
        .tick   (tick)
    );

    // Load beats start beats tick; the final tick either expires or reloads
    always_ff @(posedge SC_downCOUNTER_CLOCK_50 or negedge SC_downCOUNTER_RESET_InLow) begin
        if (!SC_downCOUNTER_RESET_InLow) begin
            state       <= IDLE;
            count       <= '0;
            reloadValue <= '0;
            tcReg       <= 1'b0;
        end else begin
            tcReg <= 1'b0;
            if (!SC_downCOUNTER_load_InLow) begin
                count       <= SC_downCOUNTER_preset_InBUS;
                reloadValue <= SC_downCOUNTER_preset_InBUS;
                state       <= IDLE;
            end else if (startOk) begin
                state <= RUN;
            end else if (tick) begin
                if (count > DATAWIDTH'(1)) begin
                    count <= count - 1'b1;
                end else begin
                    tcReg <= 1'b1;
                    if (AUTO_RELOAD != 0) begin
                        count <= reloadValue;
                    end else begin
                        count <= '0;
                        state <= EXPIRED;
                    end
                end
            end
        end
    end

    assign SC_downCOUNTER_data_OutBUS = count;
    assign SC_downCOUNTER_zero_Out    = (count == '0);
    assign SC_downCOUNTER_tc_Out      = tcReg;
    assign SC_downCOUNTER_busy_Out    = (state == RUN);

endmodule

// File: tb/tb_sc_downcounter_timer.sv
// tb_sc_downcounter_timer: directed checks of one-shot, pause, priority, auto-reload and reset behaviour
module tb_sc_downcounter_timer;

    logic       clk;
    logic       rstN;
    logic       loadN;
    logic       startN;
    logic       pauseN;
    logic [7:0] preset;

    logic [7:0] data0, dataAr, dataP1;
    logic       zero0, zeroAr, zeroP1;
    logic       tc0, tcAr, tcP1;
    logic       busy0, busyAr, busyP1;

    int checks = 0;
    int errors = 0;

    sc_downcounter_timer #(.DATAWIDTH(8), .PRESCALE(4), .AUTO_RELOAD(0)) dut (
        .SC_downCOUNTER_CLOCK_50     (clk),
        .SC_downCOUNTER_RESET_InLow  (rstN),
        .SC_downCOUNTER_load_InLow   (loadN),
        .SC_downCOUNTER_preset_InBUS (preset),
        .SC_downCOUNTER_start_InLow  (startN),
        .SC_downCOUNTER_pause_InLow  (pauseN),
        .SC_downCOUNTER_data_OutBUS  (data0),
        .SC_downCOUNTER_zero_Out     (zero0),
        .SC_downCOUNTER_tc_Out       (tc0),
        .SC_downCOUNTER_busy_Out     (busy0)
    );

    sc_downcounter_timer #(.DATAWIDTH(8), .PRESCALE(4), .AUTO_RELOAD(1)) dutAr (
        .SC_downCOUNTER_CLOCK_50     (clk),
        .SC_downCOUNTER_RESET_InLow  (rstN),
        .SC_downCOUNTER_load_InLow   (loadN),
        .SC_downCOUNTER_preset_InBUS (preset),
        .SC_downCOUNTER_start_InLow  (startN),
        .SC_downCOUNTER_pause_InLow  (pauseN),
        .SC_downCOUNTER_data_OutBUS  (dataAr),
        .SC_downCOUNTER_zero_Out     (zeroAr),
        .SC_downCOUNTER_tc_Out       (tcAr),
        .SC_downCOUNTER_busy_Out     (busyAr)
    );

    sc_downcounter_timer #(.DATAWIDTH(8), .PRESCALE(1), .AUTO_RELOAD(0)) dutP1 (
        .SC_downCOUNTER_CLOCK_50     (clk),
        .SC_downCOUNTER_RESET_InLow  (rstN),
        .SC_downCOUNTER_load_InLow   (loadN),
        .SC_downCOUNTER_preset_InBUS (preset),
        .SC_downCOUNTER_start_InLow  (startN),
        .SC_downCOUNTER_pause_InLow  (pauseN),
        .SC_downCOUNTER_data_OutBUS  (dataP1),
        .SC_downCOUNTER_zero_Out     (zeroP1),
        .SC_downCOUNTER_tc_Out       (tcP1),
        .SC_downCOUNTER_busy_Out     (busyP1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus changes on the falling edge; the next rising edge samples it
    task automatic doLoad(input logic [7:0] v);
        loadN  = 1'b0;
        preset = v;
        @(negedge clk);
        loadN  = 1'b1;
    endtask

    task automatic doStart();
        startN = 1'b0;
        @(negedge clk);
        startN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b1; loadN = 1'b1; startN = 1'b1; pauseN = 1'b1; preset = 8'd0;
        #1 rstN = 1'b0;
        #1;
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL reset_data got %0d want 0", data0); end
        checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_shot();
        doLoad(8'd3);
        checks++; if (data0 !== 8'd3) begin errors++; $display("FAIL load3_data got %0d want 3", data0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL load3_busy got %b want 0", busy0); end
        doStart();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy0); end
        repeat (3) @(negedge clk);
        checks++; if (data0 !== 8'd3) begin errors++; $display("FAIL os_k3 got %0d want 3", data0); end
        @(negedge clk);
        checks++; if (data0 !== 8'd2) begin errors++; $display("FAIL os_k4 got %0d want 2", data0); end
        repeat (4) @(negedge clk);
        checks++; if (data0 !== 8'd1) begin errors++; $display("FAIL os_k8 got %0d want 1", data0); end
        repeat (3) @(negedge clk);
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL os_k11_tc got %b want 0", tc0); end
        @(negedge clk);
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL os_k12_data got %0d want 0", data0); end
        checks++; if (tc0 !== 1'b1) begin errors++; $display("FAIL os_k12_tc got %b want 1", tc0); end
        checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL os_k12_zero got %b want 1", zero0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL os_k12_busy got %b want 0", busy0); end
        @(negedge clk);
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL os_k13_tc got %b want 0", tc0); end
        doStart();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL expired_start_busy got %b want 0", busy0); end
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL expired_start_data got %0d want 0", data0); end
    endtask

    task automatic test_pause();
        doLoad(8'd2);
        doStart();
        pauseN = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++; if (busy0 !== 1'b1 || data0 !== 8'd2) begin errors++; $display("FAIL pause_hold%0d got busy=%b data=%0d want busy=1 data=2", i, busy0, data0); end
        end
        pauseN = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data0 !== 8'd2) begin errors++; $display("FAIL pause_k8 got %0d want 2", data0); end
        @(negedge clk);
        checks++; if (data0 !== 8'd1) begin errors++; $display("FAIL pause_k9 got %0d want 1", data0); end
        repeat (3) @(negedge clk);
        checks++; if (data0 !== 8'd1 || tc0 !== 1'b0) begin errors++; $display("FAIL pause_k12 got data=%0d tc=%b want data=1 tc=0", data0, tc0); end
        @(negedge clk);
        checks++; if (data0 !== 8'd0 || tc0 !== 1'b1) begin errors++; $display("FAIL pause_k13 got data=%0d tc=%b want data=0 tc=1", data0, tc0); end
    endtask

    task automatic test_ignored_starts();
        doLoad(8'd0);
        doStart();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL start_zero_busy got %b want 0", busy0); end
        checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL start_zero_zero got %b want 1", zero0); end
    endtask

    task automatic test_load_priority();
        doLoad(8'd2);
        doStart();
        repeat (3) @(negedge clk);
        doLoad(8'd5);
        checks++; if (data0 !== 8'd5) begin errors++; $display("FAIL load_tick_data got %0d want 5", data0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL load_tick_busy got %b want 0", busy0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL load_tick_tc got %b want 0", tc0); end
        repeat (4) @(negedge clk);
        checks++; if (data0 !== 8'd5) begin errors++; $display("FAIL load_idle_hold got %0d want 5", data0); end
    endtask

    task automatic test_auto_reload();
        logic [7:0] expData;
        logic       expTc;
        doLoad(8'd2);
        doStart();
        checks++; if (dataAr !== 8'd2 || busyAr !== 1'b1) begin errors++; $display("FAIL ar_start got data=%0d busy=%b want data=2 busy=1", dataAr, busyAr); end
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            expData = ((j / 4) % 2 == 0) ? 8'd2 : 8'd1;
            expTc   = (j % 8 == 0);
            checks++; if (dataAr !== expData || tcAr !== expTc || zeroAr !== 1'b0) begin errors++; $display("FAIL ar_cycle%0d got data=%0d tc=%b zero=%b want data=%0d tc=%b zero=0", j, dataAr, tcAr, zeroAr, expData, expTc); end
        end
        checks++; if (busyAr !== 1'b1) begin errors++; $display("FAIL ar_busy got %b want 1", busyAr); end
    endtask

    task automatic test_reset_mid_run();
        doLoad(8'd9);
        doStart();
        repeat (8) @(negedge clk);
        checks++; if (data0 !== 8'd7) begin errors++; $display("FAIL mid_pre got %0d want 7", data0); end
        #2 rstN = 1'b0;
        #1;
        checks++; if (data0 !== 8'd0 || busy0 !== 1'b0 || tc0 !== 1'b0 || zero0 !== 1'b1) begin errors++; $display("FAIL mid_reset got data=%0d busy=%b tc=%b zero=%b want 0 0 0 1", data0, busy0, tc0, zero0); end
        @(negedge clk);
        rstN = 1'b1;
        doStart();
        repeat (5) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || data0 !== 8'd0) begin errors++; $display("FAIL mid_start_after got busy=%b data=%0d want 0 0", busy0, data0); end
    endtask

    task automatic test_prescale_one();
        doLoad(8'd1);
        doStart();
        checks++; if (dataP1 !== 8'd1 || busyP1 !== 1'b1) begin errors++; $display("FAIL p1_k0 got data=%0d busy=%b want 1 1", dataP1, busyP1); end
        @(negedge clk);
        checks++; if (dataP1 !== 8'd0 || tcP1 !== 1'b1 || zeroP1 !== 1'b1) begin errors++; $display("FAIL p1_k1 got data=%0d tc=%b zero=%b want 0 1 1", dataP1, tcP1, zeroP1); end
        @(negedge clk);
        checks++; if (tcP1 !== 1'b0) begin errors++; $display("FAIL p1_k2_tc got %b want 0", tcP1); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_pause();
        test_ignored_starts();
        test_load_priority();
        test_auto_reload();
        test_reset_mid_run();
        test_prescale_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
